// File: rtl/span_tier_spread_engine.sv
// ---------------------------------------------------------------------------
// span_tier_spread_engine
//   SPAN intra-commodity tier-spread engine. Captures a snapshot of per-tier
//   long/short positions and charges, walks every tier pair (i<j) in
//   lexicographic order one per cycle, nets opposing positions into spread
//   charges, then charges leftover positions per tier at outright rates.
//
//   Optional build macro: SPAN_TIER_SAT_EN
//     defined   -> accumulators clamp to 2^ACC_W-1 on overflow
//     undefined -> accumulators wrap modulo 2^ACC_W
//   overflow is sticky per job in both builds.
//
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   in_valid/ready   snapshot handshake (ready only while idle)
//   long_in/short_in packed per-tier positions, tier 0 in LSBs
//   spread_chg       packed per-pair spread charge, pair 0 in LSBs
//   outright_chg     packed per-tier outright charge
//   out_valid/ready  result handshake, outputs held until accepted
//   spread_total     accumulated spread charge
//   outright_total   accumulated outright charge
//   long_res/short_res residual positions
//   overflow         an accumulator carried out of ACC_W during this job
// ---------------------------------------------------------------------------
module span_tier_spread_engine #(
    parameter  int NUM_TIERS = 4,
    parameter  int POS_W     = 7,
    parameter  int CHG_W     = 8,
    parameter  int ACC_W     = 20,
    localparam int NUM_PAIRS = NUM_TIERS * (NUM_TIERS - 1) / 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_TIERS*POS_W-1:0]    long_in,
    input  logic [NUM_TIERS*POS_W-1:0]    short_in,
    input  logic [NUM_PAIRS*CHG_W-1:0]    spread_chg,
    input  logic [NUM_TIERS*CHG_W-1:0]    outright_chg,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              spread_total,
    output logic [ACC_W-1:0]              outright_total,
    output logic [NUM_TIERS*POS_W-1:0]    long_res,
    output logic [NUM_TIERS*POS_W-1:0]    short_res,
    output logic                          overflow
);

    localparam int TW     = $clog2(NUM_TIERS);
    localparam int PIW    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int PROD_W = CHG_W + POS_W + 1;
    // Sum wide enough to expose the carry even when a product is wider than
    // the accumulator.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    localparam logic [TW-1:0]  LAST_T = TW'(NUM_TIERS - 1);
    localparam logic [PIW-1:0] LAST_P = PIW'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {IDLE, PAIR, OUTR, DONE} state_t;

    state_t state_q, state_d;

    logic [NUM_TIERS-1:0][POS_W-1:0] long_q, long_d, short_q, short_d;
    logic [NUM_PAIRS-1:0][CHG_W-1:0] spr_q, spr_d;
    logic [NUM_TIERS-1:0][CHG_W-1:0] outr_q, outr_d;
    logic [PIW-1:0]                  p_q, p_d;
    logic [TW-1:0]                   i_q, i_d, j_q, j_d, t_q, t_d;
    logic [ACC_W-1:0]                sacc_q, sacc_d, oacc_q, oacc_d;
    logic                            ovf_q, ovf_d;

    logic [POS_W-1:0]  l_i, s_i, l_j, s_j, m_a, m_b;
    logic [POS_W:0]    m_sum, t_sum;
    logic [PROD_W-1:0] sp_prod, or_prod;
    logic [ACC_W:0]    sp_add, or_add;

    // Returns {carry, result}; result wraps or clamps depending on build.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0]  a,
                                               input logic [PROD_W-1:0] b);
        logic [SUM_W-1:0] s;
        logic             c;
        s = SUM_W'(a) + SUM_W'(b);
        c = |s[SUM_W-1:ACC_W];
`ifdef SPAN_TIER_SAT_EN
        return {c, c ? {ACC_W{1'b1}} : s[ACC_W-1:0]};
`else
        return {c, s[ACC_W-1:0]};
`endif
    endfunction

    // Pair datapath: cross-match long of one tier against short of the other.
    always_comb begin
        l_i     = long_q[i_q];
        s_i     = short_q[i_q];
        l_j     = long_q[j_q];
        s_j     = short_q[j_q];
        m_a     = (l_i < s_j) ? l_i : s_j;
        m_b     = (s_i < l_j) ? s_i : l_j;
        m_sum   = {1'b0, m_a} + {1'b0, m_b};
        sp_prod = PROD_W'(spr_q[p_q]) * PROD_W'(m_sum);
        t_sum   = {1'b0, long_q[t_q]} + {1'b0, short_q[t_q]};
        or_prod = PROD_W'(outr_q[t_q]) * PROD_W'(t_sum);
        sp_add  = acc_add(sacc_q, sp_prod);
        or_add  = acc_add(oacc_q, or_prod);
    end

    always_comb begin
        state_d = state_q;
        long_d  = long_q;
        short_d = short_q;
        spr_d   = spr_q;
        outr_d  = outr_q;
        p_d     = p_q;
        i_d     = i_q;
        j_d     = j_q;
        t_d     = t_q;
        sacc_d  = sacc_q;
        oacc_d  = oacc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    long_d  = long_in;
                    short_d = short_in;
                    spr_d   = spread_chg;
                    outr_d  = outright_chg;
                    p_d     = '0;
                    i_d     = '0;
                    j_d     = TW'(1);
                    t_d     = '0;
                    sacc_d  = '0;
                    oacc_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = PAIR;
                end
            end
            PAIR: begin
                long_d[i_q]  = l_i - m_a;
                short_d[j_q] = s_j - m_a;
                short_d[i_q] = s_i - m_b;
                long_d[j_q]  = l_j - m_b;
                sacc_d       = sp_add[ACC_W-1:0];
                ovf_d        = ovf_q | sp_add[ACC_W];
                if (p_q == LAST_P) begin
                    t_d     = '0;
                    state_d = OUTR;
                end else begin
                    p_d = p_q + 1'b1;
                    // j wraps past the last tier: advance i, restart j at i+1
                    if (j_q == LAST_T) begin
                        i_d = i_q + 1'b1;
                        j_d = i_q + TW'(2);
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            OUTR: begin
                oacc_d = or_add[ACC_W-1:0];
                ovf_d  = ovf_q | or_add[ACC_W];
                if (t_q == LAST_T) state_d = DONE;
                else               t_d     = t_q + 1'b1;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            long_q  <= '0;
            short_q <= '0;
            spr_q   <= '0;
            outr_q  <= '0;
            p_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            t_q     <= '0;
            sacc_q  <= '0;
            oacc_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            long_q  <= long_d;
            short_q <= short_d;
            spr_q   <= spr_d;
            outr_q  <= outr_d;
            p_q     <= p_d;
            i_q     <= i_d;
            j_q     <= j_d;
            t_q     <= t_d;
            sacc_q  <= sacc_d;
            oacc_q  <= oacc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Gated by reset so the engine never advertises ready while held in reset.
    assign in_ready       = (state_q == IDLE) && reset;
    assign out_valid      = (state_q == DONE);
    assign spread_total   = sacc_q;
    assign outright_total = oacc_q;
    assign long_res       = long_q;
    assign short_res      = short_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_span_tier_spread_engine.sv
module tb_span_tier_spread_engine;

    localparam int NT = 4;
    localparam int PW = 7;
    localparam int CW = 8;
    localparam int NP = 6;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic [NT*PW-1:0] long_in = '0, short_in = '0;
    logic [NP*CW-1:0] spread_chg = '0;
    logic [NT*CW-1:0] outright_chg = '0;

    logic in_ready, out_valid, overflow;
    logic [AW-1:0] spread_total, outright_total;
    logic [NT*PW-1:0] long_res, short_res;

    logic in_ready8, out_valid8, overflow8;
    logic [7:0] spread_total8, outright_total8;
    logic [NT*PW-1:0] long_res8, short_res8;

    always #5 clk = ~clk;

    span_tier_spread_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .long_in(long_in), .short_in(short_in), .spread_chg(spread_chg),
        .outright_chg(outright_chg), .out_valid(out_valid), .out_ready(out_ready),
        .spread_total(spread_total), .outright_total(outright_total),
        .long_res(long_res), .short_res(short_res), .overflow(overflow)
    );

    span_tier_spread_engine #(.ACC_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .long_in(long_in), .short_in(short_in), .spread_chg(spread_chg),
        .outright_chg(outright_chg), .out_valid(out_valid8), .out_ready(out_ready8),
        .spread_total(spread_total8), .outright_total(outright_total8),
        .long_res(long_res8), .short_res(short_res8), .overflow(overflow8)
    );

    typedef struct {
        string            name;
        logic [NT*PW-1:0] l, s;
        logic [NP*CW-1:0] sc;
        logic [NT*CW-1:0] oc;
        int               e_sp, e_or;
        logic [NT*PW-1:0] e_l, e_s;
        logic             e_ovf;
    } vec_t;

    int n_pass = 0, n_tot = 0;

    function automatic logic [NT*PW-1:0] pos4(input int a0, a1, a2, a3);
        return {PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
    endfunction
    function automatic logic [NT*CW-1:0] oc4(input int a0, a1, a2, a3);
        return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
    endfunction
    function automatic logic [NP*CW-1:0] sc6(input int a0, a1, a2, a3, a4, a5);
        return {CW'(a5), CW'(a4), CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    // Present a snapshot, then count cycles until out_valid (bounded).
    task automatic start_job(input vec_t v, output int lat);
        @(negedge clk);
        long_in = v.l; short_in = v.s; spread_chg = v.sc; outright_chg = v.oc;
        in_valid = 1'b1;
        chk({v.name, " in_ready before accept"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input vec_t v, input int lat);
        chk({v.name, " latency"}, lat, 11);
        chk({v.name, " spread_total"}, spread_total, v.e_sp);
        chk({v.name, " outright_total"}, outright_total, v.e_or);
        chk({v.name, " long_res"}, long_res, v.e_l);
        chk({v.name, " short_res"}, short_res, v.e_s);
        chk({v.name, " overflow"}, overflow, v.e_ovf);
    endtask

    task automatic release_job(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " out_valid after release"}, out_valid, 0);
        chk({nm, " in_ready after release"}, in_ready, 1);
    endtask

    vec_t vecs[6];

    initial begin
        int lat;
        int seen;
        logic [7:0] exp8;

        vecs[0] = '{"single", pos4(5,0,0,0), pos4(0,3,0,0), sc6(10,7,7,7,7,7),
                    oc4(2,2,2,2), 30, 4, pos4(2,0,0,0), pos4(0,0,0,0), 1'b0};
        vecs[1] = '{"cross", pos4(4,9,0,0), pos4(6,1,0,0), sc6(5,0,0,0,0,0),
                    oc4(1,1,1,1), 35, 6, pos4(3,3,0,0), pos4(0,0,0,0), 1'b0};
        vecs[2] = '{"zero", pos4(0,0,0,0), pos4(0,0,0,0), sc6(9,9,9,9,9,9),
                    oc4(9,9,9,9), 0, 0, pos4(0,0,0,0), pos4(0,0,0,0), 1'b0};
        vecs[3] = '{"multi", pos4(3,0,4,0), pos4(0,2,0,7), sc6(1,2,3,4,5,6),
                    oc4(1,2,3,4), 29, 8, pos4(0,0,0,0), pos4(0,0,0,2), 1'b0};
        vecs[4] = '{"maxpair", pos4(127,0,0,127), pos4(0,127,127,0),
                    sc6(255,255,255,255,255,255), oc4(255,255,255,255),
                    64770, 0, pos4(0,0,0,0), pos4(0,0,0,0), 1'b0};
        vecs[5] = '{"maxoutr", pos4(127,127,127,127), pos4(0,0,0,0),
                    sc6(255,255,255,255,255,255), oc4(255,255,255,255),
                    0, 129540, pos4(127,127,127,127), pos4(0,0,0,0), 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst in_ready held", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst spread_total", spread_total, 0);
        chk("rst outright_total", outright_total, 0);
        chk("rst long_res", long_res, 0);
        chk("rst overflow", overflow, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst in_ready released", in_ready, 1);

        // Table-driven jobs
        for (int k = 0; k < 6; k++) begin
            start_job(vecs[k], lat);
            check_result(vecs[k], lat);
            release_job(vecs[k].name);
        end

        // Backpressure: hold DONE, ignore a new snapshot, then accept next
        start_job(vecs[1], lat);
        check_result(vecs[1], lat);
        in_valid = 1'b1;
        long_in = pos4(1,1,1,1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp out_valid held", out_valid, 1);
            chk("bp in_ready low", in_ready, 0);
            chk("bp spread stable", spread_total, 35);
            chk("bp long_res stable", long_res, pos4(3,3,0,0));
        end
        in_valid = 1'b0;
        release_job("bp");
        start_job(vecs[0], lat);
        check_result(vecs[0], lat);
        release_job("bp next");

        // Reset during PAIR aborts the job
        start_job(vecs[3], lat);  // runs to completion; used only to warm state
        release_job("pre-abort");
        @(negedge clk);
        long_in = vecs[3].l; short_in = vecs[3].s;
        spread_chg = vecs[3].sc; outright_chg = vecs[3].oc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready held", in_ready, 0);
        chk("abort spread_total", spread_total, 0);
        chk("abort outright_total", outright_total, 0);
        chk("abort long_res", long_res, 0);
        chk("abort short_res", short_res, 0);
        chk("abort overflow", overflow, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort in_ready after", in_ready, 1);
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort no out_valid", seen, 0);
        start_job(vecs[1], lat);
        check_result(vecs[1], lat);
        release_job("post-abort");

        // Overflow on an 8-bit accumulator
`ifdef SPAN_TIER_SAT_EN
        exp8 = 8'd255;
`else
        exp8 = 8'd129;
`endif
        @(negedge clk);
        long_in = pos4(127,0,0,0); short_in = pos4(0,127,0,0);
        spread_chg = sc6(255,0,0,0,0,0); outright_chg = oc4(3,3,3,3);
        in_valid8 = 1'b1;
        chk("ovf8 in_ready", in_ready8, 1);
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ovf8 latency", lat, 11);
        chk("ovf8 overflow", overflow8, 1);
        chk("ovf8 spread_total", spread_total8, exp8);
        chk("ovf8 outright_total", outright_total8, 0);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("ovf8 in_ready after", in_ready8, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
